// File: rtl/segrx_pkg.sv
// segrx_pkg: shared types and constants for the 7-segment scan receiver.
// Holds the segment patterns for digits 0..9, the active-low one-hot digit
// select codes, the digit-index / BCD types and the registered sample layout.
package segrx_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Segment patterns, bits {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Digit select codes, active-low one-hot.
  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b0111;

  // One registered snapshot of the scan bus; dat is already polarity-corrected.
  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] dat;
  } sample_t;

  // Result of decoding a select value: valid only for exactly one low line.
  typedef struct packed {
    logic       valid;
    digit_idx_t idx;
  } sel_dec_t;

  function automatic sel_dec_t decode_sel(input logic [3:0] sel);
    sel_dec_t d;
    d.valid = 1'b1;
    d.idx   = 2'd0;
    case (sel)
      SEL_D0:  d.idx = 2'd0;
      SEL_D1:  d.idx = 2'd1;
      SEL_D2:  d.idx = 2'd2;
      SEL_D3:  d.idx = 2'd3;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_scan_rx_seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment pattern to BCD decoder.
// Any pattern other than the ten digit shapes reports o_valid=0.
module seg7_to_bcd
  import segrx_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output bcd_t       o_bcd
);

  // Pattern lookup; unknown shapes are flagged rather than guessed.
  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned, which would otherwise infer a latch.
    o_valid = 1'b1;
    o_bcd   = 4'd0;
    case (i_seg)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: snoops a multiplexed 4-digit 7-segment scan bus, waits for
// each digit to be stable for STABLE_CYC samples, decodes it back to BCD and
// hands complete 4-digit frames to a consumer over valid/ready.
// Build option SEGRX_DP_EN: when defined, the decimal point of each digit is
// captured, delivered on dp_out and takes part in the stability compare;
// when undefined, dp is masked off before the compare and dp_out reads 0.
module seg_scan_rx
  import segrx_pkg::*;
#(
  parameter int STABLE_CYC  = 4,    // identical samples needed for a capture (>=2)
  parameter bit SEG_ACT_LOW = 1'b0  // 1: segment lines are active-low
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_sel_in,
  input  logic [7:0]  seg_dat_in,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] digits_out,
  output logic [3:0]  dp_out,
  output logic        err_out,
  output logic [1:0]  err_digit
);

  localparam int               CNT_W   = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

`ifdef SEGRX_DP_EN
  localparam logic [7:0] DAT_KEEP = 8'hFF;
`else
  // dp is forced to 0 so dp flicker can never break a digit's stability.
  localparam logic [7:0] DAT_KEEP = 8'h7F;
`endif

  // ---------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------
  logic [7:0] w_dat_pos;
  sample_t    w_sample;
  sample_t    r_smp;
  sample_t    r_prev;

  assign w_dat_pos = SEG_ACT_LOW ? ~seg_dat_in : seg_dat_in;
  assign w_sample  = '{sel: seg_sel_in, dat: w_dat_pos & DAT_KEEP};

  // Register the bus once and keep the previous sample for the stability compare.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge value of the others (r_prev really is the old r_smp).
    if (rst) begin
      r_smp  <= '0;
      r_prev <= '0;
    end else begin
      r_smp  <= w_sample;
      r_prev <= r_smp;
    end
  end

  // ---------------------------------------------------------------------
  // Stability counter and capture strobe
  // ---------------------------------------------------------------------
  sel_dec_t         w_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;

  assign w_sel = decode_sel(r_smp.sel);

  // Count identical consecutive samples, saturating; invalid selects pin it at 0.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_sel.valid) begin
      w_cnt_nxt = '0;
    end else if (r_smp != r_prev) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Stability counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Fires exactly once per stable run: on the step into saturation.
  assign w_capture = w_sel.valid && (w_cnt_nxt == CNT_MAX) && (r_cnt != CNT_MAX);

  // ---------------------------------------------------------------------
  // Segment decode
  // ---------------------------------------------------------------------
  logic w_seg_valid;
  bcd_t w_seg_bcd;
  logic w_cap_ok;
  logic w_cap_bad;

  seg7_to_bcd u_dec (
    .i_seg   (r_smp.dat[6:0]),
    .o_valid (w_seg_valid),
    .o_bcd   (w_seg_bcd)
  );

  assign w_cap_ok  = w_capture &&  w_seg_valid;
  assign w_cap_bad = w_capture && !w_seg_valid;

  // ---------------------------------------------------------------------
  // Shadow digits, capture mask, frame load
  // ---------------------------------------------------------------------
  bcd_t [3:0] r_shadow;
  logic [3:0] r_mask;
  logic [3:0] w_mask_nxt;
  logic       r_frame_valid;
  logic       w_complete;
  logic       w_load;

  assign w_complete = (r_mask == 4'hF);
  assign w_load     = w_complete && (!r_frame_valid || frame_ready);

  // A load empties the mask; a capture in the same cycle then starts the next frame.
  always_comb begin
    w_mask_nxt = r_mask;
    if (w_load) begin
      w_mask_nxt = 4'h0;
    end
    if (w_capture) begin
      w_mask_nxt[w_sel.idx] = w_seg_valid;
    end
  end

  // Capture mask register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= 4'h0;
    end else begin
      r_mask <= w_mask_nxt;
    end
  end

  // Shadow digit store; bad patterns leave the previous value untouched.
  always_ff @(posedge clk) begin
    // NOTE: the shadow digits are reset along with the control state so a
    // frame started after reset can never deliver stale digits.
    if (rst) begin
      r_shadow <= '0;
    end else if (w_cap_ok) begin
      r_shadow[w_sel.idx] <= w_seg_bcd;
    end
  end

  // ---------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------
  logic       r_err;
  digit_idx_t r_err_digit;

  // One-cycle error pulse with the index of the digit that carried it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_err_digit <= 2'd0;
    end else begin
      r_err <= w_cap_bad;
      if (w_cap_bad) begin
        r_err_digit <= w_sel.idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output frame and handshake
  // ---------------------------------------------------------------------
  logic [15:0] r_digits;

  // Load the shadow when a frame is complete and the output is free; drop
  // valid once the consumer takes the frame and nothing new is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_valid <= 1'b0;
      r_digits      <= 16'h0000;
    end else if (w_load) begin
      r_frame_valid <= 1'b1;
      r_digits      <= r_shadow;
    end else if (r_frame_valid && frame_ready) begin
      r_frame_valid <= 1'b0;
    end
  end

`ifdef SEGRX_DP_EN
  logic [3:0] r_shadow_dp;
  logic [3:0] r_dp_out;

  // Decimal-point shadow, updated alongside the digit it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_dp <= 4'h0;
    end else if (w_cap_ok) begin
      r_shadow_dp[w_sel.idx] <= r_smp.dat[7];
    end
  end

  // Decimal-point output, loaded together with the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_out <= 4'h0;
    end else if (w_load) begin
      r_dp_out <= r_shadow_dp;
    end
  end

  assign dp_out = r_dp_out;
`else
  assign dp_out = 4'b0000;
`endif

  assign frame_valid = r_frame_valid;
  assign digits_out  = r_digits;
  assign err_out     = r_err;
  assign err_digit   = r_err_digit;

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: directed scenarios followed by random scan traffic for
// seg_scan_rx. Expected frames and errors come from a frame-level model that
// tracks runs of identical bus values and assembles digits into frames.
// Honours SEGRX_DP_EN the same way the design does.
module tb_seg_scan_rx;

  localparam int STABLE = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef SEGRX_DP_EN
  localparam logic [3:0] EXP_DP6 = 4'b0001;
`else
  localparam logic [3:0] EXP_DP6 = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  seg_sel_in;
  logic [7:0]  seg_dat_in;
  logic        frame_ready;
  logic        frame_valid;
  logic [15:0] digits_out;
  logic [3:0]  dp_out;
  logic        err_out;
  logic [1:0]  err_digit;

  always #5 clk = ~clk;

  seg_scan_rx #(.STABLE_CYC(STABLE), .SEG_ACT_LOW(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_sel_in  (seg_sel_in),
    .seg_dat_in  (seg_dat_in),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .digits_out  (digits_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .err_digit   (err_digit)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } frame_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic        run_valid;
  logic [11:0] run_v;
  int          run_len;
  frame_t      exp_frames [$];
  int          exp_errs [$];

  int frames_seen = 0;
  int errs_seen   = 0;
  int fv_cycles   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sel_of(input int i);
    return ~(4'b0001 << i);
  endfunction

  function automatic int sel_idx(input logic [3:0] sel);
    if ($countones(~sel) != 1) return -1;
    for (int i = 0; i < 4; i++) if (!sel[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_dp      = 4'h0;
    m_mask    = 4'h0;
    run_valid = 1'b0;
    run_v     = 12'h000;
    run_len   = 0;
    exp_frames.delete();
    exp_errs.delete();
  endtask

  // A stable digit arrived: decode it and assemble frames.
  task automatic m_capture(input int idx, input logic [7:0] dat);
    int bcd;
    bcd = -1;
    for (int i = 0; i < 10; i++) if (dat[6:0] == SEG_TAB[i]) bcd = i;
    if (bcd < 0) begin
      exp_errs.push_back(idx);
      m_mask[idx] = 1'b0;
    end else begin
      m_shadow[idx] = 4'(bcd);
`ifdef SEGRX_DP_EN
      m_dp[idx] = dat[7];
`endif
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_frames.push_back('{digits: {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]},
                               dp: m_dp});
        m_mask = 4'h0;
      end
    end
  endtask

  // One clock: observe outputs at the negedge, then advance.
  task automatic cycle();
    frame_t f;
    if (err_out === 1'b1) begin
      errs_seen++;
      if (exp_errs.size() == 0) check("err_unexpected", err_out, 1'b0);
      else check("err_digit", err_digit, exp_errs.pop_front());
    end
    if (frame_valid === 1'b1) fv_cycles++;
    if (frame_valid === 1'b1 && frame_ready) begin
      frames_seen++;
      if (exp_frames.size() == 0) check("frame_unexpected", frame_valid, 1'b0);
      else begin
        f = exp_frames.pop_front();
        check("frame_digits", digits_out, f.digits);
        check("frame_dp", dp_out, f.dp);
      end
    end
    @(negedge clk);
  endtask

  // Hold one bus value for n cycles; the model sees it as part of a run.
  task automatic hold(input logic [3:0] sel, input logic [7:0] dat, input int n);
    logic [11:0] v;
    int          old_len;
    int          idx;
`ifdef SEGRX_DP_EN
    v = {sel, dat};
`else
    v = {sel, 1'b0, dat[6:0]};
`endif
    seg_sel_in = sel;
    seg_dat_in = dat;
    old_len = (run_valid && v == run_v) ? run_len : 0;
    run_valid = 1'b1;
    run_v     = v;
    run_len   = old_len + n;
    idx       = sel_idx(sel);
    if (idx >= 0 && old_len < STABLE && run_len >= STABLE) m_capture(idx, dat);
    repeat (n) cycle();
  endtask

  task automatic idle(input int n);
    hold(4'hF, 8'h00, n);
  endtask

  task automatic scan4(input logic [7:0] d3, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0);
    hold(sel_of(3), d3, STABLE);
    hold(sel_of(2), d2, STABLE);
    hold(sel_of(1), d1, STABLE);
    hold(sel_of(0), d0, STABLE);
  endtask

  task automatic wait_frame(input int max_cyc);
    int k;
    k = 0;
    while (frame_valid !== 1'b1 && k < max_cyc) begin
      cycle();
      k++;
    end
    check("wait_frame_valid", frame_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    seg_sel_in = 4'hF;
    seg_dat_in = 8'h00;
    cycle();
    cycle();
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_digits", digits_out, 16'h0000);
    check("rst_dp", dp_out, 4'h0);
    check("rst_err", err_out, 1'b0);
    check("rst_err_digit", err_digit, 2'd0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int f0;
    int e0;
    rst         = 1'b1;
    seg_sel_in  = 4'hF;
    seg_dat_in  = 8'h00;
    frame_ready = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // Basic frame with ready high: valid for exactly one cycle.
    fv_cycles = 0;
    f0 = frames_seen;
    scan4({1'b0, SEG_TAB[1]}, {1'b0, SEG_TAB[2]}, {1'b0, SEG_TAB[3]}, {1'b0, SEG_TAB[4]});
    idle(8);
    check("t1_frames", frames_seen - f0, 1);
    check("t1_valid_cycles", fv_cycles, 1);
    check("t1_digits", digits_out, 16'h1234);

    // Back-pressure: frame held steady until accepted, then valid drops.
    frame_ready = 1'b0;
    f0 = frames_seen;
    scan4({1'b0, SEG_TAB[1]}, {1'b0, SEG_TAB[2]}, {1'b0, SEG_TAB[3]}, {1'b0, SEG_TAB[4]});
    idle(2);
    wait_frame(20);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", frame_valid, 1'b1);
      check("t2_hold_digits", digits_out, 16'h1234);
      cycle();
    end
    frame_ready = 1'b1;
    cycle();
    check("t2_drop", frame_valid, 1'b0);
    check("t2_frames", frames_seen - f0, 1);

    // Bad pattern on d1: one error pulse, no frame until d1 is valid.
    f0 = frames_seen;
    e0 = errs_seen;
    scan4({1'b0, SEG_TAB[1]}, {1'b0, SEG_TAB[2]}, 8'h7C, {1'b0, SEG_TAB[4]});
    idle(8);
    check("t3_err_count", errs_seen - e0, 1);
    check("t3_no_frame", frames_seen - f0, 0);
    hold(sel_of(1), {1'b0, SEG_TAB[3]}, STABLE);
    idle(8);
    check("t3_frames", frames_seen - f0, 1);
    check("t3_digits", digits_out, 16'h1234);

    // d2 glitching every 3 cycles never becomes stable.
    f0 = frames_seen;
    e0 = errs_seen;
    hold(sel_of(3), {1'b0, SEG_TAB[5]}, STABLE);
    hold(sel_of(1), {1'b0, SEG_TAB[6]}, STABLE);
    hold(sel_of(0), {1'b0, SEG_TAB[7]}, STABLE);
    for (int i = 0; i < 4; i++) hold(sel_of(2), {1'b0, SEG_TAB[2 + (i % 2)]}, 3);
    idle(6);
    check("t4_no_frame", frames_seen - f0, 0);
    check("t4_valid_low", frame_valid, 1'b0);

    // Two selects low at once: ignored entirely.
    hold(4'b0011, {1'b0, SEG_TAB[8]}, 8);
    idle(6);
    check("t5_bad_sel_frames", frames_seen - f0, 0);
    check("t5_bad_sel_errs", errs_seen - e0, 0);
    hold(sel_of(2), {1'b0, SEG_TAB[8]}, STABLE);
    idle(6);
    check("t5_frames", frames_seen - f0, 1);
    check("t5_digits", digits_out, 16'h5867);

    // Reset mid-frame discards the partial frame.
    f0 = frames_seen;
    hold(sel_of(3), {1'b0, SEG_TAB[9]}, STABLE);
    hold(sel_of(2), {1'b0, SEG_TAB[9]}, STABLE);
    do_reset();
    hold(sel_of(1), {1'b0, SEG_TAB[1]}, STABLE);
    hold(sel_of(0), {1'b0, SEG_TAB[2]}, STABLE);
    idle(6);
    check("t5_rst_no_frame", frames_seen - f0, 0);
    hold(sel_of(3), {1'b0, SEG_TAB[3]}, STABLE);
    hold(sel_of(2), {1'b0, SEG_TAB[4]}, STABLE);
    idle(6);
    check("t5_rst_frames", frames_seen - f0, 1);
    check("t5_rst_digits", digits_out, 16'h3412);

    // Decimal point on d0.
    scan4({1'b0, SEG_TAB[0]}, {1'b0, SEG_TAB[0]}, {1'b0, SEG_TAB[0]}, 8'h86);
    idle(6);
    check("t6_d0", digits_out[3:0], 4'd1);
    check("t6_dp", dp_out, EXP_DP6);

    // Random scan traffic with glitches, bad patterns and idle gaps.
    f0 = frames_seen;
    for (int f = 0; f < 20; f++) begin
      int start;
      start = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        logic [3:0] sel;
        logic [7:0] dat;
        sel = sel_of((start + k) % 4);
        if ($urandom_range(0, 7) == 0) hold(sel, 8'($urandom), $urandom_range(1, STABLE - 1));
        dat = {1'($urandom_range(0, 1)), SEG_TAB[$urandom_range(0, 9)]};
        if ($urandom_range(0, 11) == 0) dat = 8'($urandom);
        hold(sel, dat, $urandom_range(STABLE, STABLE + 3));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
    idle(10);
    check("rand_pending_frames", exp_frames.size(), 0);
    check("rand_pending_errs", exp_errs.size(), 0);
    check("rand_valid_low", frame_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
